// File: rtl/framebuffer_ctrl.sv
// framebuffer_ctrl
// Full-screen pixel store between the drawing writers and the panel refresher.
// A synchronous-read block memory holds SCREEN_W*SCREEN_H pixels at
// address y*SCREEN_W + x. Three engines share it:
//   - single-pixel write port (wr_valid/wr_ready); off-screen pixels are
//     accepted and dropped
//   - rectangle fill engine (fill_start pulse, one pixel per clock, clipped
//     to the screen)
//   - windowed read-out streamer (rd_start pulse) feeding a 2-entry skid
//     buffer with px_valid/px_ready back-pressure
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   wr_valid, wr_ready, wr_x, wr_y,
//   wr_data                           single-pixel write
//   fill_start, fill_x, fill_y,
//   fill_w, fill_h, fill_color,
//   fill_busy                         rectangle fill
//   rd_start, rd_x0, rd_y0, rd_x1,
//   rd_y1, rd_busy                    inclusive window stream control
//   px_valid, px_ready, px_data,
//   px_last                           streamed pixel output
module framebuffer_ctrl #(
  parameter int SCREEN_W = 240,
  parameter int SCREEN_H = 320,
  parameter int PIX_W    = 16,
  parameter int ADDR_W   = $clog2(SCREEN_W*SCREEN_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [15:0]       wr_x,
  input  logic [15:0]       wr_y,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              fill_start,
  input  logic [15:0]       fill_x,
  input  logic [15:0]       fill_y,
  input  logic [15:0]       fill_w,
  input  logic [15:0]       fill_h,
  input  logic [PIX_W-1:0]  fill_color,
  output logic              fill_busy,
  input  logic              rd_start,
  input  logic [15:0]       rd_x0,
  input  logic [15:0]       rd_y0,
  input  logic [15:0]       rd_x1,
  input  logic [15:0]       rd_y1,
  output logic              rd_busy,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [PIX_W-1:0]  px_data,
  output logic              px_last
);

  localparam int          DEPTH = SCREEN_W * SCREEN_H;
  localparam logic [15:0] W16   = 16'(SCREEN_W);
  localparam logic [15:0] H16   = 16'(SCREEN_H);

  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_FILL  = 1'b1;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_RUN   = 2'd1;
  localparam logic [1:0] R_DRAIN = 2'd2;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [15:0] x,
                                                 input logic [15:0] y);
    return ADDR_W'(32'(y) * 32'(SCREEN_W) + 32'(x));
  endfunction

  logic [PIX_W-1:0]  mem_r [DEPTH];

  // write engine state
  logic [0:0]        wstate_r;
  logic [15:0]       fx0_r, fy0_r, fcw_r, fch_r, fcx_r, fcy_r;
  logic [PIX_W-1:0]  fcolor_r;

  // read engine state and skid buffer
  logic [1:0]        rstate_r;
  logic [15:0]       rx0_r, rx1_r, ry1_r, cur_x_r, cur_y_r;
  logic [1:0]        fifo_cnt_r;
  logic              fifo_wp_r, fifo_rp_r;
  logic [1:0]        fifo_last_r;
  logic [PIX_W-1:0]  fifo_data_r [2];

  logic [15:0]       fill_xrem_s, fill_yrem_s, fill_cw_s, fill_ch_s;
  logic              fill_ok_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [PIX_W-1:0]  mem_wdata_s;
  logic              rd_win_ok_s;
  logic              pop_s, issue_s, last_addr_s;
  logic [ADDR_W-1:0] rd_addr_s;

  // Rectangle clipping; the remainder subtraction is only meaningful when
  // the origin is on-screen, which fill_ok_s also requires.
  assign fill_xrem_s = W16 - fill_x;
  assign fill_yrem_s = H16 - fill_y;
  assign fill_cw_s   = (fill_w < fill_xrem_s) ? fill_w : fill_xrem_s;
  assign fill_ch_s   = (fill_h < fill_yrem_s) ? fill_h : fill_yrem_s;
  assign fill_ok_s   = (fill_x < W16) && (fill_y < H16) &&
                       (fill_cw_s != 16'd0) && (fill_ch_s != 16'd0);

  assign wr_ready  = (wstate_r == W_IDLE) && !fill_start;
  assign fill_busy = (wstate_r == W_FILL);

  // Single memory write port: the fill engine owns it while filling.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = {ADDR_W{1'b0}};
    mem_wdata_s = {PIX_W{1'b0}};
    if (wstate_r == W_FILL) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = pix_addr(fx0_r + fcx_r, fy0_r + fcy_r);
      mem_wdata_s = fcolor_r;
    end else if (wr_valid && wr_ready && (wr_x < W16) && (wr_y < H16)) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = pix_addr(wr_x, wr_y);
      mem_wdata_s = wr_data;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Write FSM: idle/single writes versus row-major rectangle fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_r <= W_IDLE;
      fx0_r    <= 16'd0;
      fy0_r    <= 16'd0;
      fcw_r    <= 16'd0;
      fch_r    <= 16'd0;
      fcx_r    <= 16'd0;
      fcy_r    <= 16'd0;
      fcolor_r <= {PIX_W{1'b0}};
    end else begin
      case (wstate_r)
        W_IDLE: begin
          if (fill_start && fill_ok_s) begin
            fx0_r    <= fill_x;
            fy0_r    <= fill_y;
            fcw_r    <= fill_cw_s;
            fch_r    <= fill_ch_s;
            fcx_r    <= 16'd0;
            fcy_r    <= 16'd0;
            fcolor_r <= fill_color;
            wstate_r <= W_FILL;
          end
        end
        W_FILL: begin
          if (fcx_r == fcw_r - 16'd1) begin
            fcx_r <= 16'd0;
            if (fcy_r == fch_r - 16'd1) begin
              wstate_r <= W_IDLE;
            end else begin
              fcy_r <= fcy_r + 16'd1;
            end
          end else begin
            fcx_r <= fcx_r + 16'd1;
          end
        end
        default: wstate_r <= W_IDLE;
      endcase
    end
  end

  assign rd_win_ok_s = (rd_x0 <= rd_x1) && (rd_x1 < W16) &&
                       (rd_y0 <= rd_y1) && (rd_y1 < H16);
  assign pop_s       = (fifo_cnt_r != 2'd0) && px_ready;
  // The read result lands straight in the skid buffer at the issue edge, so
  // there is never a read in flight: issuing is safe whenever the buffer
  // is not full after this cycle's pop.
  assign issue_s     = (rstate_r == R_RUN) && ((fifo_cnt_r != 2'd2) || pop_s);
  assign last_addr_s = (cur_x_r == rx1_r) && (cur_y_r == ry1_r);
  assign rd_addr_s   = pix_addr(cur_x_r, cur_y_r);

  assign px_valid = (fifo_cnt_r != 2'd0);
  assign px_data  = px_valid ? fifo_data_r[fifo_rp_r] : {PIX_W{1'b0}};
  assign px_last  = px_valid & fifo_last_r[fifo_rp_r];
  assign rd_busy  = (rstate_r != R_IDLE);

  // Block memory: write port plus synchronous read into the skid buffer slot
  // (old data on a same-address same-cycle read). Contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
    if (issue_s) begin
      fifo_data_r[fifo_wp_r] <= mem_r[rd_addr_s];
    end
  end

  // Read FSM, address walker and skid buffer bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_r    <= R_IDLE;
      rx0_r       <= 16'd0;
      rx1_r       <= 16'd0;
      ry1_r       <= 16'd0;
      cur_x_r     <= 16'd0;
      cur_y_r     <= 16'd0;
      fifo_cnt_r  <= 2'd0;
      fifo_wp_r   <= 1'b0;
      fifo_rp_r   <= 1'b0;
      fifo_last_r <= 2'b00;
    end else begin
      case ({issue_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
      if (issue_s) begin
        fifo_last_r[fifo_wp_r] <= last_addr_s;
        fifo_wp_r              <= ~fifo_wp_r;
      end
      if (pop_s) begin
        fifo_rp_r <= ~fifo_rp_r;
      end
      case (rstate_r)
        R_IDLE: begin
          if (rd_start && rd_win_ok_s) begin
            rx0_r    <= rd_x0;
            rx1_r    <= rd_x1;
            ry1_r    <= rd_y1;
            cur_x_r  <= rd_x0;
            cur_y_r  <= rd_y0;
            rstate_r <= R_RUN;
          end
        end
        R_RUN: begin
          if (issue_s) begin
            if (last_addr_s) begin
              rstate_r <= R_DRAIN;
            end else if (cur_x_r == rx1_r) begin
              cur_x_r <= rx0_r;
              cur_y_r <= cur_y_r + 16'd1;
            end else begin
              cur_x_r <= cur_x_r + 16'd1;
            end
          end
        end
        R_DRAIN: begin
          if (pop_s && px_last) begin
            rstate_r <= R_IDLE;
          end
        end
        default: rstate_r <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_ctrl.sv
module tb_framebuffer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_x = 16'd0, wr_y = 16'd0, wr_data = 16'd0;
  logic        fill_start = 1'b0;
  logic [15:0] fill_x = 16'd0, fill_y = 16'd0, fill_w = 16'd0, fill_h = 16'd0;
  logic [15:0] fill_color = 16'd0;
  logic        fill_busy;
  logic        rd_start = 1'b0;
  logic [15:0] rd_x0 = 16'd0, rd_y0 = 16'd0, rd_x1 = 16'd0, rd_y1 = 16'd0;
  logic        rd_busy;
  logic        px_valid;
  logic        px_ready = 1'b0;
  logic [15:0] px_data;
  logic        px_last;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] mdl [0:76799];

  framebuffer_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data),
    .fill_start(fill_start), .fill_x(fill_x), .fill_y(fill_y),
    .fill_w(fill_w), .fill_h(fill_h), .fill_color(fill_color),
    .fill_busy(fill_busy),
    .rd_start(rd_start), .rd_x0(rd_x0), .rd_y0(rd_y0), .rd_x1(rd_x1),
    .rd_y1(rd_y1), .rd_busy(rd_busy),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .px_last(px_last)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_pixel(input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] d);
    step();
    wr_x = x; wr_y = y; wr_data = d; wr_valid = 1'b1;
    #1;
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_ready(%0d,%0d): got %b want 1", x, y, wr_ready);
    end
    step();
    wr_valid = 1'b0;
    if (x < 16'd240 && y < 16'd320) mdl[int'(y) * 240 + int'(x)] = d;
  endtask

  task automatic do_fill(input int x, input int y, input int w, input int h,
                         input logic [15:0] c, input int exp_busy,
                         input string name);
    int   busy_cnt;
    logic first_busy;
    busy_cnt = 0;
    step();
    fill_x = 16'(x); fill_y = 16'(y); fill_w = 16'(w); fill_h = 16'(h);
    fill_color = c; fill_start = 1'b1;
    #1;
    vectors++;
    if (wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s wr_ready_on_start: got %b want 0", name, wr_ready);
    end
    step();
    fill_start = 1'b0;
    first_busy = fill_busy;
    for (int k = 0; k < exp_busy + 3; k++) begin
      if (fill_busy === 1'b1) busy_cnt++;
      step();
    end
    vectors++;
    if (first_busy !== (exp_busy != 0)) begin
      miscompares++;
      $display("FAIL %s busy_first_cycle: got %b want %b", name, first_busy,
               (exp_busy != 0));
    end
    vectors++;
    if (busy_cnt != exp_busy) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp_busy);
    end
    for (int yy = y; yy < y + h; yy++)
      for (int xx = x; xx < x + w; xx++)
        if (xx < 240 && yy < 320) mdl[yy * 240 + xx] = c;
  endtask

  task automatic stream(input int x0, input int y0, input int x1, input int y1,
                        input bit rnd, input bit poke, input string name);
    int   p, k, cyc, cx, cy, first_valid, last_cyc, errs;
    logic hold, hold_l;
    logic [15:0] hold_d, want;
    p = (x1 - x0 + 1) * (y1 - y0 + 1);
    k = 0; cyc = 0; cx = x0; cy = y0; first_valid = -1; last_cyc = -1;
    errs = 0; hold = 1'b0; hold_l = 1'b0; hold_d = 16'd0;
    step();
    rd_x0 = 16'(x0); rd_y0 = 16'(y0); rd_x1 = 16'(x1); rd_y1 = 16'(y1);
    rd_start = 1'b1;
    while (k < p && cyc < 4 * p + 20) begin
      step();
      cyc++;
      rd_start = 1'b0;
      if (poke && cyc == 3) begin
        rd_x0 = 16'd0; rd_y0 = 16'd0; rd_x1 = 16'd0; rd_y1 = 16'd0;
        rd_start = 1'b1;
      end
      px_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_busy !== 1'b1) begin
        if (errs < 4) $display("FAIL %s rd_busy cycle %0d: got %b want 1", name, cyc, rd_busy);
        errs++;
      end
      if (px_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (hold && (px_valid !== 1'b1 || px_data !== hold_d || px_last !== hold_l)) begin
        if (errs < 4) $display("FAIL %s hold cycle %0d: got %b/%h/%b want 1/%h/%b",
                               name, cyc, px_valid, px_data, px_last, hold_d, hold_l);
        errs++;
      end
      if (px_valid === 1'b1 && px_ready) begin
        want = mdl[cy * 240 + cx];
        if (px_data !== want || px_last !== (k == p - 1)) begin
          if (errs < 4) $display("FAIL %s pixel %0d (%0d,%0d): got %h last %b want %h last %b",
                                 name, k, cx, cy, px_data, px_last, want, (k == p - 1));
          errs++;
        end
        if (k == p - 1) last_cyc = cyc;
        if (cx == x1) begin cx = x0; cy++; end else cx++;
        k++;
        hold = 1'b0;
      end else if (px_valid === 1'b1) begin
        hold = 1'b1; hold_d = px_data; hold_l = px_last;
      end else begin
        hold = 1'b0;
      end
    end
    step();
    px_ready = 1'b0;
    vectors++;
    if (k != p) begin
      miscompares++;
      $display("FAIL %s pixel_count: got %0d want %0d", name, k, p);
    end
    vectors++;
    if (rd_busy !== 1'b0 || px_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_after: got busy %b valid %b want 0 0", name, rd_busy, px_valid);
    end
    vectors++;
    if (first_valid != 2) begin
      miscompares++;
      $display("FAIL %s first_valid_latency: got %0d want 2", name, first_valid);
    end
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL %s stream_content: got %0d bad cycles want 0", name, errs);
    end
    if (!rnd) begin
      vectors++;
      if (last_cyc != p + 1) begin
        miscompares++;
        $display("FAIL %s last_cycle: got %0d want %0d", name, last_cyc, p + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({fill_busy, rd_busy, px_valid, px_last} !== 4'b0000 || px_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got fb%b rb%b v%b l%b d%h want all 0",
               fill_busy, rd_busy, px_valid, px_last, px_data);
    end
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    wr_pixel(16'd3, 16'd5, 16'hF800);
    stream(3, 5, 3, 5, 1'b0, 1'b0, "single_px");
  endtask

  task automatic test_out_of_range();
    do_fill(0, 0, 240, 2, 16'h0001, 480, "fill_rows01");
    wr_pixel(16'd240, 16'd0, 16'h1234);
    stream(0, 0, 239, 1, 1'b0, 1'b0, "rows01");
  endtask

  task automatic test_fill_clip();
    do_fill(229, 309, 11, 11, 16'h001F, 121, "fill_corner_bg");
    do_fill(230, 310, 20, 20, 16'h07E0, 100, "fill_clipped");
    stream(229, 309, 239, 319, 1'b0, 1'b0, "corner");
  endtask

  task automatic test_fill_ignored();
    do_fill(240, 0, 5, 5, 16'hDEAD, 0, "fill_x_off");
    do_fill(0, 320, 5, 5, 16'hDEAD, 0, "fill_y_off");
    do_fill(10, 10, 0, 5, 16'hDEAD, 0, "fill_w_zero");
    do_fill(10, 10, 5, 0, 16'hDEAD, 0, "fill_h_zero");
  endtask

  task automatic test_fill_write_collide();
    int busy, cyc;
    bit blocked_ok, done, accept_ok;
    busy = 0; cyc = 0; blocked_ok = 1'b1; done = 1'b0; accept_ok = 1'b0;
    step();
    fill_x = 16'd50; fill_y = 16'd50; fill_w = 16'd4; fill_h = 16'd3;
    fill_color = 16'h5555; fill_start = 1'b1;
    wr_x = 16'd60; wr_y = 16'd60; wr_data = 16'hBEEF; wr_valid = 1'b1;
    #1;
    vectors++;
    if (wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_start_wr_ready: got %b want 0", wr_ready);
    end
    step();
    fill_start = 1'b0;
    while (!done && cyc < 40) begin
      if (fill_busy === 1'b1) begin
        busy++;
        if (wr_ready !== 1'b0) blocked_ok = 1'b0;
        step();
        cyc++;
      end else begin
        done = 1'b1;
        accept_ok = (wr_ready === 1'b1) && (busy > 0);
      end
    end
    step();
    wr_valid = 1'b0;
    vectors++;
    if (busy != 12) begin
      miscompares++;
      $display("FAIL collide_busy_cycles: got %0d want 12", busy);
    end
    vectors++;
    if (!blocked_ok) begin
      miscompares++;
      $display("FAIL collide_wr_blocked: got wr_ready=1 during fill want 0");
    end
    vectors++;
    if (!accept_ok) begin
      miscompares++;
      $display("FAIL collide_accept: got wr_ready %b after fill want 1", wr_ready);
    end
    for (int yy = 50; yy < 53; yy++)
      for (int xx = 50; xx < 54; xx++) mdl[yy * 240 + xx] = 16'h5555;
    mdl[60 * 240 + 60] = 16'hBEEF;
    stream(60, 60, 60, 60, 1'b0, 1'b0, "collide_px");
    stream(50, 50, 53, 52, 1'b0, 1'b0, "collide_fill");
  endtask

  task automatic test_invalid_window();
    logic [15:0] bad [4][4];
    bad[0] = '{16'd5, 16'd0, 16'd4, 16'd0};
    bad[1] = '{16'd0, 16'd0, 16'd240, 16'd0};
    bad[2] = '{16'd0, 16'd7, 16'd0, 16'd6};
    bad[3] = '{16'd0, 16'd0, 16'd0, 16'd320};
    for (int i = 0; i < 4; i++) begin
      step();
      rd_x0 = bad[i][0]; rd_y0 = bad[i][1]; rd_x1 = bad[i][2]; rd_y1 = bad[i][3];
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      step();
      vectors++;
      if (rd_busy !== 1'b0 || px_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL bad_window_%0d: got busy %b valid %b want 0 0", i, rd_busy, px_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int y = 20; y < 28; y++)
      for (int x = 0; x < 16; x++)
        wr_pixel(16'(x), 16'(y), 16'((y << 8) | x) ^ 16'h3C00);
    stream(0, 20, 15, 27, 1'b1, 1'b1, "bp_random");
    stream(0, 20, 15, 27, 1'b1, 1'b0, "bp_random2");
  endtask

  task automatic test_back_to_back();
    stream(229, 309, 239, 319, 1'b0, 1'b0, "b2b_a");
    stream(3, 5, 3, 5, 1'b0, 1'b0, "b2b_b");
  endtask

  task automatic test_reset_mid_stream();
    step();
    rd_x0 = 16'd0; rd_y0 = 16'd0; rd_x1 = 16'd239; rd_y1 = 16'd1; rd_start = 1'b1;
    fill_x = 16'd100; fill_y = 16'd100; fill_w = 16'd10; fill_h = 16'd10;
    fill_color = 16'h00FF; fill_start = 1'b1;
    px_ready = 1'b1;
    step();
    rd_start = 1'b0; fill_start = 1'b0;
    repeat (10) step();
    vectors++;
    if (px_valid !== 1'b1 || fill_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_running: got valid %b fill_busy %b want 1 1", px_valid, fill_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({px_valid, rd_busy, px_last, fill_busy} !== 4'b0000 || px_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got v%b rb%b l%b fb%b d%h want all 0",
               px_valid, rd_busy, px_last, fill_busy, px_data);
    end
    px_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stream(3, 5, 3, 5, 1'b0, 1'b0, "post_reset_px");
    stream(229, 309, 239, 319, 1'b0, 1'b0, "post_reset_corner");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_out_of_range();
    test_fill_clip();
    test_fill_ignored();
    test_fill_write_collide();
    test_invalid_window();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/framebuffer_ctrl.md
# framebuffer_ctrl

Parametrised full-screen pixel store with three engines: a single-pixel write port with valid/ready, a hardware rectangle-fill engine, and a windowed read-out streamer with valid/ready back-pressure. It sits between the glyph/drawing writers (e.g. gb2312_char_writer) and the SPI panel refresher, replacing combinational read-out with a synchronous-read BRAM plus a skid buffer so it maps to block RAM at full throughput.

## Interface
- SCREEN_W, 240, pixels per row
- SCREEN_H, 320, rows
- PIX_W, 16, bits per pixel (RGB565 default)
- ADDR_W, $clog2(SCREEN_W*SCREEN_H), memory address width

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- wr_valid  in  1  single-pixel write request
- wr_ready  out  1  write engine can accept a pixel
- wr_x, wr_y  in  16  write coordinates
- wr_data  in  PIX_W  write pixel
- fill_start  in  1  one-cycle pulse: start rectangle fill
- fill_x, fill_y, fill_w, fill_h  in  16  rectangle origin and size
- fill_color  in  PIX_W  fill pixel
- fill_busy  out  1  fill in progress
- rd_start  in  1  one-cycle pulse: start window stream
- rd_x0, rd_y0, rd_x1, rd_y1  in  16  inclusive window corners
- rd_busy  out  1  stream in progress
- px_valid  out  1  px_data valid
- px_ready  in  1  consumer accepts pixel
- px_data  out  PIX_W  streamed pixel
- px_last  out  1  marks final pixel of window, qualified by px_valid

## Operation
- Memory: SCREEN_W*SCREEN_H words of PIX_W, address = y*SCREEN_W + x (ADDR_W bits). One write port, one synchronous read port; same-address same-cycle read returns old data. Contents not reset.
- Write FSM states W_IDLE, W_FILL.
- W_IDLE: wr_ready = (state==W_IDLE) && !fill_start (combinational). Handshake wr_valid&&wr_ready writes wr_data if wr_x<SCREEN_W and wr_y<SCREEN_H; out-of-range pixels are accepted and dropped.
- fill_start in W_IDLE: latch clipped rectangle cw = min(fill_w, SCREEN_W-fill_x), ch = min(fill_h, SCREEN_H-fill_y); if fill_x>=SCREEN_W, fill_y>=SCREEN_H, cw==0 or ch==0 → ignored, stay W_IDLE. Else → W_FILL. fill_start has priority over wr_valid in the same cycle.
- W_FILL: one pixel per clock, row-major, x inner. After pixel (cw-1,ch-1) → W_IDLE. fill_start during W_FILL ignored; wr_ready=0.
- Read FSM states R_IDLE, R_RUN, R_DRAIN.
- rd_start in R_IDLE with rd_x0<=rd_x1<SCREEN_W and rd_y0<=rd_y1<SCREEN_H: latch window → R_RUN. Invalid window or rd_start while busy: ignored.
- R_RUN: issue read addresses row-major; address advances only when the 2-entry skid buffer will have room, so no pixel is lost or duplicated under any px_ready pattern. After final address issued → R_DRAIN.
- R_DRAIN: wait until last pixel handshakes (px_valid&&px_ready&&px_last) → R_IDLE.
- Writes (single or fill) may run concurrently with streaming; streamed pixel reflects memory at its read-issue cycle.

## Timing
- Reset (async assert, sync release): write/read FSMs idle, fill_busy=0, rd_busy=0, px_valid=0, px_last=0, px_data=0; skid buffer emptied. Reset mid-fill or mid-stream aborts immediately; already-written pixels remain.
- Single write: data in memory at the handshake edge; readable by a read issued the next cycle.
- fill_busy: high from cycle after fill_start for exactly cw*ch cycles; wr_ready returns the cycle fill_busy falls.
- Stream: rd_start at cycle N → first read address N+1 → px_valid at N+2. With px_ready held high, one pixel per clock; total window of P pixels ends with px_last at N+1+P.
- px_data/px_last stable while px_valid && !px_ready.
- rd_busy: high from N+1 through cycle of last handshake; low the following cycle; new rd_start accepted then.

## Test plan
- Write (3,5)=0xF800, stream window (3,5)-(3,5) → single pixel 0xF800 with px_last=1, px_valid at N+2.
- Write x=240,y=0 value 0x1234 → accepted (wr_ready=1), memory unchanged; stream (0,0)-(239,0) shows no 0x1234.
- fill (230,310) w=20 h=20 color 0x07E0 → clipped 10x10, fill_busy high exactly 100 cycles; stream (229,309)-(239,319) → corner row/column unchanged, rest 0x07E0.
- fill_start and wr_valid same cycle → wr_ready=0, fill runs, write accepted the cycle after fill_busy falls.
- Stream 240x320 with random px_ready (50%) → 76800 pixels in row-major order, no loss/duplication, px_last only on final; with px_ready=1 finishes at N+76801.
- Assert rst_n low mid-stream → px_valid/rd_busy drop immediately; after release a new stream returns pre-reset memory contents.
